uart_tx_scheduler: RTL and testbench

//  Shares one UART transmitter among N_REQ byte requesters using round-robin arbitration.

---
 rtl/uart_tx_pkg.sv | 29 ++
 rtl/uart_tx_rr_arb.sv | 39 +++
 rtl/uart_tx_scheduler.sv | 178 +++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared types and defaults for the UART TX scheduler slice.
// The optional inter-frame gap is enabled by defining UART_TX_GAP_EN.
package uart_tx_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_BUSY = 2'd1,
      WAIT_DONE = 2'd2,
      GAP       = 2'd3
   } sched_state_t;

   localparam int DEF_N_REQ      = 32'sd4;
   localparam int DEF_DATA_W     = 32'sd8;
   localparam int DEF_BUSY_TMO   = 32'sd8;
   localparam int DEF_GAP_CYCLES = 32'sd2;

   // Index width for n requesters; never below one bit.
   function automatic int id_width(input int n);
      int w;
      w = 32'sd1;
      if (n > 32'sd2) begin
         w = $clog2(n);
      end else begin
         w = 32'sd1;
      end
      return w;
   endfunction

endpackage

// File: rtl/uart_tx_rr_arb.sv
// Combinational round-robin pick: the first active request at or after rr_ptr,
// wrapping modulo N_REQ. The pointer register lives in the scheduler.
module uart_tx_rr_arb
   import uart_tx_pkg::*;
#(
   parameter int N_REQ = DEF_N_REQ,
   parameter int ID_W  = id_width(DEF_N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  rr_ptr,
   output logic             valid,
   output logic [ID_W-1:0]  winner
);

   // Pick the requester with the smallest rotational distance from rr_ptr.
   always_comb begin
      int off_s;
      int best_off_s;
      valid      = |req;
      winner     = rr_ptr;
      off_s      = 32'sd0;
      best_off_s = N_REQ;
      for (int j = 0; j < N_REQ; j++) begin
         off_s = j - int'(rr_ptr);
         if (off_s < 32'sd0) begin
            off_s = off_s + N_REQ;
         end else begin
            off_s = off_s;
         end
         if (req[j] && (off_s < best_off_s)) begin
            best_off_s = off_s;
            winner     = ID_W'(j);
         end else begin
            best_off_s = best_off_s;
         end
      end
   end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter among N_REQ byte requesters,
// with a busy-rise watchdog. Define UART_TX_GAP_EN to add idle cycles between frames.
module uart_tx_scheduler
   import uart_tx_pkg::*;
#(
   parameter int N_REQ      = DEF_N_REQ,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int BUSY_TMO   = DEF_BUSY_TMO,
   parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic [N_REQ-1:0]           REQ,
   input  logic [N_REQ*DATA_W-1:0]    REQ_DATA,
   output logic [N_REQ-1:0]           GNT,
   output logic                       Data_Valid,
   output logic [DATA_W-1:0]          P_DATA,
   input  logic                       busy,
   output logic [id_width(N_REQ)-1:0] ACTIVE_ID,
   output logic                       TMO_ERR
);

   localparam int ID_W  = id_width(N_REQ);
   localparam int TMO_W = $clog2(BUSY_TMO + 1);

   localparam logic [ID_W-1:0]   ID_ONE   = ID_W'(1'b1);
   localparam logic [ID_W-1:0]   ID_LAST  = ID_W'(N_REQ - 1);
   localparam logic [TMO_W-1:0]  TMO_ONE  = TMO_W'(1'b1);
   localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(BUSY_TMO - 1);
   localparam logic [N_REQ-1:0]  GNT_ONE  = N_REQ'(1'b1);

`ifdef UART_TX_GAP_EN
   localparam int GAP_W = $clog2(GAP_CYCLES + 1);
   localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1'b1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

   logic [GAP_W-1:0]  gap_cnt_r;
   logic [GAP_W-1:0]  gap_cnt_s;
`endif

   sched_state_t      state_r;
   sched_state_t      state_s;
   logic [ID_W-1:0]   rr_ptr_r;
   logic [ID_W-1:0]   rr_ptr_s;
   logic [N_REQ-1:0]  gnt_r;
   logic [N_REQ-1:0]  gnt_s;
   logic              dv_r;
   logic              dv_s;
   logic [DATA_W-1:0] p_data_r;
   logic [DATA_W-1:0] p_data_s;
   logic [ID_W-1:0]   active_id_r;
   logic [ID_W-1:0]   active_id_s;
   logic              tmo_err_r;
   logic              tmo_err_s;
   logic [TMO_W-1:0]  busy_cnt_r;
   logic [TMO_W-1:0]  busy_cnt_s;

   logic              arb_valid_s;
   logic [ID_W-1:0]   win_s;
   logic [DATA_W-1:0] req_byte_s [N_REQ];

   for (genvar g = 0; g < N_REQ; g++) begin : g_byte
      assign req_byte_s[g] = REQ_DATA[g*DATA_W +: DATA_W];
   end

   uart_tx_rr_arb #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_arb (
      .req    (REQ),
      .rr_ptr (rr_ptr_r),
      .valid  (arb_valid_s),
      .winner (win_s)
   );

   // Next-state and next-output logic; every output is registered below.
   always_comb begin
      state_s     = state_r;
      rr_ptr_s    = rr_ptr_r;
      gnt_s       = {N_REQ{1'b0}};
      dv_s        = 1'b0;
      p_data_s    = p_data_r;
      active_id_s = active_id_r;
      tmo_err_s   = 1'b0;
      busy_cnt_s  = busy_cnt_r;
`ifdef UART_TX_GAP_EN
      gap_cnt_s   = gap_cnt_r;
`endif
      case (state_r)
         IDLE: begin
            if (arb_valid_s && !busy) begin
               gnt_s       = GNT_ONE << win_s;
               dv_s        = 1'b1;
               p_data_s    = req_byte_s[win_s];
               active_id_s = win_s;
               rr_ptr_s    = (win_s == ID_LAST) ? {ID_W{1'b0}} : (win_s + ID_ONE);
               busy_cnt_s  = {TMO_W{1'b0}};
               state_s     = WAIT_BUSY;
            end else begin
               state_s     = IDLE;
            end
         end
         // The byte is dropped on timeout; rr_ptr has already moved past it.
         WAIT_BUSY: begin
            if (busy) begin
               state_s    = WAIT_DONE;
            end else if (busy_cnt_r == TMO_LAST) begin
               tmo_err_s  = 1'b1;
               state_s    = IDLE;
            end else begin
               busy_cnt_s = busy_cnt_r + TMO_ONE;
            end
         end
         WAIT_DONE: begin
            if (busy) begin
               state_s   = WAIT_DONE;
            end else begin
`ifdef UART_TX_GAP_EN
               gap_cnt_s = {GAP_W{1'b0}};
               state_s   = GAP;
`else
               state_s   = IDLE;
`endif
            end
         end
         GAP: begin
`ifdef UART_TX_GAP_EN
            if (gap_cnt_r == GAP_LAST) begin
               state_s   = IDLE;
            end else begin
               gap_cnt_s = gap_cnt_r + GAP_ONE;
            end
`else
            state_s = IDLE;
`endif
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_r     <= IDLE;
         rr_ptr_r    <= {ID_W{1'b0}};
         gnt_r       <= {N_REQ{1'b0}};
         dv_r        <= 1'b0;
         p_data_r    <= {DATA_W{1'b0}};
         active_id_r <= {ID_W{1'b0}};
         tmo_err_r   <= 1'b0;
         busy_cnt_r  <= {TMO_W{1'b0}};
`ifdef UART_TX_GAP_EN
         gap_cnt_r   <= {GAP_W{1'b0}};
`endif
      end else begin
         state_r     <= state_s;
         rr_ptr_r    <= rr_ptr_s;
         gnt_r       <= gnt_s;
         dv_r        <= dv_s;
         p_data_r    <= p_data_s;
         active_id_r <= active_id_s;
         tmo_err_r   <= tmo_err_s;
         busy_cnt_r  <= busy_cnt_s;
`ifdef UART_TX_GAP_EN
         gap_cnt_r   <= gap_cnt_s;
`endif
      end
   end

   assign GNT        = gnt_r;
   assign Data_Valid = dv_r;
   assign P_DATA     = p_data_r;
   assign ACTIVE_ID  = active_id_r;
   assign TMO_ERR    = tmo_err_r;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with a small UART busy model.
// Gap timing expectations follow UART_TX_GAP_EN.
module tb_uart_tx_scheduler;

   localparam int N_REQ = 4;
   localparam int DATA_W = 8;
`ifdef UART_TX_GAP_EN
   localparam int FALL_TO_DV = 4;
`else
   localparam int FALL_TO_DV = 2;
`endif

   logic                    CLK;
   logic                    RST;
   logic [N_REQ-1:0]        REQ;
   logic [N_REQ*DATA_W-1:0] REQ_DATA;
   logic [N_REQ-1:0]        GNT;
   logic                    Data_Valid;
   logic [DATA_W-1:0]       P_DATA;
   logic                    busy;
   logic [1:0]              ACTIVE_ID;
   logic                    TMO_ERR;

   logic model_busy = 1'b0;
   logic busy_force = 1'b0;
   logic uart_auto  = 1'b1;
   logic dv_mid     = 1'b0;
   logic busy_q     = 1'b0;
   int   busy_left  = 0;

   int n_vec = 0;
   int n_err = 0;
   int dv_cnt = 0;
   int busy_rise_cnt = 0;
   int dv_in_busy = 0;
   int gnt_cnt = 0;
   int tmo_cnt = 0;

   logic [DATA_W-1:0] exp_byte [N_REQ];

   assign busy = model_busy | busy_force;

   uart_tx_scheduler dut (
      .CLK        (CLK),
      .RST        (RST),
      .REQ        (REQ),
      .REQ_DATA   (REQ_DATA),
      .GNT        (GNT),
      .Data_Valid (Data_Valid),
      .P_DATA     (P_DATA),
      .busy       (busy),
      .ACTIVE_ID  (ACTIVE_ID),
      .TMO_ERR    (TMO_ERR)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // UART model: busy rises the cycle after a load and stays high for 10 cycles.
   always @(negedge CLK) dv_mid = Data_Valid;
   always @(posedge CLK) begin
      #1;
      if (busy_left > 0) begin
         busy_left = busy_left - 1;
         if (busy_left == 0) model_busy = 1'b0;
      end else if (uart_auto && dv_mid) begin
         model_busy = 1'b1;
         busy_left  = 10;
      end
   end

   // Event counters used by the window checks.
   always @(negedge CLK) begin
      if (Data_Valid) dv_cnt = dv_cnt + 1;
      if (Data_Valid && busy) dv_in_busy = dv_in_busy + 1;
      if (busy && !busy_q) busy_rise_cnt = busy_rise_cnt + 1;
      if (|GNT) gnt_cnt = gnt_cnt + 1;
      if (TMO_ERR) tmo_cnt = tmo_cnt + 1;
      busy_q = busy;
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec = n_vec + 1;
      if (obs !== exp) begin
         n_err = n_err + 1;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_dv(input int limit, output int cyc);
      cyc = 0;
      do begin
         @(negedge CLK);
         cyc = cyc + 1;
      end while (!Data_Valid && cyc < limit);
      check_val("dv_seen", {31'd0, Data_Valid}, 32'd1);
   endtask

   task automatic wait_busy_fall(input int limit);
      int   cyc;
      logic seen_high;
      cyc = 0;
      seen_high = busy;
      do begin
         @(negedge CLK);
         cyc = cyc + 1;
         if (busy) seen_high = 1'b1;
      end while (!(seen_high && !busy) && cyc < limit);
      check_val("busy_fall", {31'd0, seen_high && !busy}, 32'd1);
   endtask

   initial begin
      int c;
      int g0;
      int d0;
      int b0;
      int i0;
      int t0;
      RST = 1'b0;
      REQ = 4'b0000;
      REQ_DATA = {8'h44, 8'hA5, 8'h22, 8'h11};
      exp_byte = '{8'h11, 8'h22, 8'hA5, 8'h44};

      // Reset values, then idle with no requests.
      repeat (3) @(negedge CLK);
      check_val("rst_gnt", GNT, 32'd0);
      check_val("rst_dv", Data_Valid, 32'd0);
      check_val("rst_pdata", P_DATA, 32'd0);
      check_val("rst_id", ACTIVE_ID, 32'd0);
      check_val("rst_tmo", TMO_ERR, 32'd0);
      @(posedge CLK); #1 RST = 1'b1;
      g0 = gnt_cnt;
      repeat (4) @(negedge CLK);
      check_val("idle_no_gnt", gnt_cnt - g0, 32'd0);

      // Single requester 2: grant one cycle after REQ.
      @(posedge CLK); #1 REQ = 4'b0100;
      @(negedge CLK);
      check_val("single_latency", GNT, 32'd0);
      @(negedge CLK);
      check_val("single_gnt", GNT, 32'h4);
      check_val("single_dv", Data_Valid, 32'd1);
      check_val("single_pdata", P_DATA, 32'hA5);
      check_val("single_id", ACTIVE_ID, 32'd2);
      REQ = 4'b0000;
      wait_busy_fall(40);
      REQ = 4'b0100;
      wait_dv(20, c);
      check_val("single_again_id", ACTIVE_ID, 32'd2);
      REQ = 4'b0000;
      wait_busy_fall(40);
      REQ = 4'b1000;
      wait_dv(20, c);
      check_val("single3_id", ACTIVE_ID, 32'd3);
      check_val("single3_pdata", P_DATA, 32'h44);
      REQ = 4'b0000;
      wait_busy_fall(40);

      // Fairness: all requesting, rr_ptr at 0.
      d0 = dv_cnt; b0 = busy_rise_cnt; i0 = dv_in_busy;
      REQ = 4'b1111;
      for (int i = 0; i < 8; i++) begin
         wait_dv(40, c);
         check_val("fair_id", ACTIVE_ID, i % 4);
         check_val("fair_gnt", GNT, 4'b0001 << (i % 4));
         check_val("fair_pdata", P_DATA, exp_byte[i % 4]);
      end
      REQ = 4'b0000;
      wait_busy_fall(40);
      check_val("fair_dv_cnt", dv_cnt - d0, 32'd8);
      check_val("fair_busy_cnt", busy_rise_cnt - b0, 32'd8);
      check_val("fair_dv_in_busy", dv_in_busy - i0, 32'd0);

      // Watchdog: UART never starts; next grant moves on to requester 1.
      uart_auto = 1'b0;
      REQ = 4'b0011;
      wait_dv(20, c);
      check_val("tmo_first_id", ACTIVE_ID, 32'd0);
      REQ = 4'b0010;
      c = 0;
      do begin
         @(negedge CLK);
         c = c + 1;
      end while (!TMO_ERR && c < 20);
      check_val("tmo_delay", c, 32'd8);
      uart_auto = 1'b1;
      @(negedge CLK);
      check_val("tmo_pulse", TMO_ERR, 32'd0);
      check_val("tmo_next_dv", Data_Valid, 32'd1);
      check_val("tmo_next_id", ACTIVE_ID, 32'd1);
      check_val("tmo_next_gnt", GNT, 32'h2);
      REQ = 4'b0000;
      wait_busy_fall(40);

      // Busy already high while idle.
      @(negedge CLK);
      busy_force = 1'b1;
      REQ = 4'b0001;
      g0 = gnt_cnt;
      repeat (20) @(negedge CLK);
      check_val("busyidle_no_gnt", gnt_cnt - g0, 32'd0);
      check_val("busyidle_gnt_now", GNT, 32'd0);
      @(posedge CLK); #1 busy_force = 1'b0;
      @(negedge CLK);
      check_val("busyidle_same_cyc", GNT, 32'd0);
      @(negedge CLK);
      check_val("busyidle_gnt", GNT, 32'h1);
      check_val("busyidle_id", ACTIVE_ID, 32'd0);
      REQ = 4'b0110;

      // Back-to-back frame spacing and a request dropped before its grant.
      wait_busy_fall(40);
      wait_dv(10, c);
      check_val("gap1_cycles", c, FALL_TO_DV);
      check_val("gap1_id", ACTIVE_ID, 32'd1);
      REQ = 4'b0100;
      wait_busy_fall(40);
      wait_dv(10, c);
      check_val("gap2_cycles", c, FALL_TO_DV);
      check_val("gap2_id", ACTIVE_ID, 32'd2);
      REQ = 4'b1001;
      repeat (3) @(negedge CLK);
      REQ = 4'b0001;
      wait_busy_fall(40);
      wait_dv(10, c);
      check_val("drop_id", ACTIVE_ID, 32'd0);
      check_val("drop_gnt", GNT, 32'h1);
      REQ = 4'b0000;
      wait_busy_fall(40);
      g0 = gnt_cnt;
      repeat (10) @(negedge CLK);
      check_val("drop_never_gnt", gnt_cnt - g0, 32'd0);

      // Reset in the load cycle clears everything at once.
      REQ = 4'b0010;
      wait_dv(20, c);
      RST = 1'b0;
      REQ = 4'b0000;
      #1;
      check_val("midrst_outputs", {16'd0, GNT, Data_Valid, P_DATA, ACTIVE_ID, TMO_ERR}, 32'd0);
      repeat (2) @(negedge CLK);
      @(posedge CLK); #1 RST = 1'b1;
      t0 = tmo_cnt;
      g0 = gnt_cnt;
      repeat (15) @(negedge CLK);
      check_val("midrst_no_tmo", tmo_cnt - t0, 32'd0);
      check_val("midrst_no_gnt", gnt_cnt - g0, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
